next_pc_ctrl: RTL and testbench
===============================

Name: next_pc_ctrl

Overview:
- Fetch-side next-PC and redirect controller for the pipelined MIPS-Lite CPU.
- Sits directly downstream of the ID-stage branch comparator and consumes its taken output (`zero`).
- Holds the architectural PC, selects the sequential, branch or jump target, and applies hazard-unit stalls.
- Issues a one-cycle IF/ID flush on every redirect so the wrong-path instruction is squashed.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_W, 32, PC / address width (fixed 32 for MIPS-Lite; parameterised for the bench only).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard-unit stall; freezes PC and FSM.
- br_taken  input  1  branch-taken from the ID-stage comparator (the `zero` signal).
- jump  input  1  ID-stage J instruction decoded.
- id_pc_plus4  input  32  PC+4 of the instruction currently in ID.
- br_offset  input  32  sign-extended 16-bit immediate of the ID instruction.
- jump_index  input  26  J-format target field.
- pc  output  32  fetch address (registered).
- pc_plus4  output  32  pc + 4, combinational, wraps mod 2^32.
- if_flush  output  1  squash IF/ID register contents (registered).
- redirect  output  1  high in the cycle a redirect target is loaded into pc.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, if_flush=0, redirect=0, state=BOOT. Asserting reset mid-flush abandons the flush immediately.
- Target arithmetic (all 32-bit, carries discarded):
  - Branch target = id_pc_plus4 + (br_offset << 2).
  - Jump target = {id_pc_plus4[31:28], jump_index, 2'b00}.
- FSM states:
  - BOOT: first clk after reset release. pc held at RESET_PC; inputs ignored. Next state RUN.
  - RUN:
    - stall=1: pc held, stay in RUN; br_taken and jump are ignored this cycle.
    - stall=0 and br_taken=1: pc<=branch target, redirect=1, next state FLUSH. br_taken has priority over jump.
    - stall=0, br_taken=0, jump=1: pc<=jump target, redirect=1, next state FLUSH.
    - Otherwise: pc<=pc+4.
  - FLUSH: if_flush=1 for exactly this one cycle. The ID slot holds the squashed wrong-path instruction, so br_taken and jump are ignored.
    - stall=0: pc<=pc+4, next state RUN.
    - stall=1: pc held, stay in FLUSH; if_flush remains 1 until the cycle stall drops.
- Timing:
  - redirect and if_flush are registered. redirect is high in the cycle pc first shows the target; if_flush is high in that same cycle.
  - Redirect latency is 1 cycle from br_taken/jump sampled high to the new pc.
- Wrap-around: pc=32'hFFFF_FFFC with sequential advance goes to 32'h0000_0000; no error is flagged.
- Misalignment: pc[1:0] stays 2'b00 by construction. RESET_PC must be word aligned; a misaligned RESET_PC is a configuration error and is not corrected.

Optional Feature:
- Macro: NEXT_PC_BR_STATS_EN.
- When defined, adds two 32-bit output ports:
  - br_count: count of accepted branch redirects.
  - jmp_count: count of accepted jump redirects.
- Counter behaviour:
  - Reset to 0 on rst_n.
  - Increment on the clock edge that accepts the redirect.
  - Saturate at 32'hFFFF_FFFF.
  - Ignored or stalled requests do not count.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset/boot: hold rst_n=0, release, RESET_PC=0 -> pc=0 for the BOOT cycle, then 4, 8, 12 on subsequent clks; if_flush=0 throughout.
- Branch: at pc=0x10, id_pc_plus4=0x0C, br_offset=3, br_taken=1 -> next pc=0x18, redirect=1, if_flush=1 for one cycle, then pc=0x1C.
- Negative branch and jump: br_offset=32'hFFFF_FFFE with id_pc_plus4=0x40 -> pc=0x38. Then jump=1, jump_index=26'h10, id_pc_plus4=0x1000_0040 -> pc=0x1000_0040.
- Stall interaction: stall=1 with br_taken=1 -> pc unchanged, no redirect. Stall drops while br_taken is still 1 -> redirect taken. Stall=1 during FLUSH -> if_flush held until stall=0.
- Ignored-in-flush: br_taken=1 asserted in the FLUSH cycle -> no second redirect; pc=target+4. Simultaneous br_taken=1 and jump=1 -> branch target wins.
- Wrap and async reset: pc=0xFFFF_FFFC advance -> 0x0. Assert rst_n low mid-FLUSH between edges -> pc=RESET_PC and if_flush=0 immediately. With NEXT_PC_BR_STATS_EN: 3 branches and 2 jumps -> br_count=3, jmp_count=2.

Source files
------------

// File: rtl/next_pc_ctrl.sv
// next_pc_ctrl: fetch-side next-PC and redirect controller for the MIPS-Lite pipeline.
//   Holds the architectural PC and selects between the sequential, branch and
//   jump targets. A registered IF/ID flush is issued on every accepted redirect,
//   and the hazard-unit stall freezes both the PC and the FSM.
//
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   stall        - hazard-unit stall; holds pc and FSM state
//   br_taken     - ID-stage comparator result (branch taken)
//   jump         - ID-stage J instruction decoded
//   id_pc_plus4  - PC+4 of the instruction in ID
//   br_offset    - sign-extended 16-bit branch immediate
//   jump_index   - J-format 26-bit target field
//   pc           - registered fetch address
//   pc_plus4     - pc + 4, combinational, wraps modulo 2^PC_W
//   if_flush     - registered IF/ID squash, high while in FLUSH
//   redirect     - registered, high in the cycle pc first shows a redirect target
//
// Optional build macro NEXT_PC_BR_STATS_EN adds saturating 32-bit counters
//   br_count / jmp_count of accepted branch / jump redirects.
module next_pc_ctrl #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_taken,
    input  logic            jump,
    input  logic [PC_W-1:0] id_pc_plus4,
    input  logic [PC_W-1:0] br_offset,
    input  logic [25:0]     jump_index,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            if_flush,
    output logic            redirect
`ifdef NEXT_PC_BR_STATS_EN
    ,
    output logic [31:0]     br_count,
    output logic [31:0]     jmp_count
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            if_flush_q, if_flush_d;
    logic            redirect_q, redirect_d;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] jmp_target;

    // Carries out of the top bit are dropped on purpose (mod 2^PC_W arithmetic).
    assign pc_plus4   = pc_q + PC_W'(4);
    assign br_target  = id_pc_plus4 + (br_offset << 2);
    assign jmp_target = {id_pc_plus4[PC_W-1:28], jump_index, 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        case (state_q)
            // One dead cycle after reset release: pc stays at RESET_PC.
            BOOT: state_d = RUN;
            RUN: begin
                if (!stall) begin
                    if (br_taken) begin
                        pc_d       = br_target;
                        redirect_d = 1'b1;
                        state_d    = FLUSH;
                    end else if (jump) begin
                        pc_d       = jmp_target;
                        redirect_d = 1'b1;
                        state_d    = FLUSH;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            // ID holds the squashed wrong-path instruction: its br_taken/jump
            // are meaningless and must not start a second redirect.
            FLUSH: begin
                if (!stall) begin
                    pc_d    = pc_plus4;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        // Flush tracks FLUSH residency, so a stall in FLUSH stretches it.
        if_flush_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            if_flush_q <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_flush_q <= if_flush_d;
            redirect_q <= redirect_d;
        end
    end

    assign pc       = pc_q;
    assign if_flush = if_flush_q;
    assign redirect = redirect_q;

`ifdef NEXT_PC_BR_STATS_EN
    logic        br_acc, jmp_acc;
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] jmp_count_q, jmp_count_d;

    // Same acceptance conditions as the RUN-state redirect decode above.
    assign br_acc  = (state_q == RUN) && !stall && br_taken;
    assign jmp_acc = (state_q == RUN) && !stall && !br_taken && jump;

    always_comb begin
        br_count_d  = br_count_q;
        jmp_count_d = jmp_count_q;
        if (br_acc && (br_count_q != 32'hFFFF_FFFF))
            br_count_d = br_count_q + 32'd1;
        if (jmp_acc && (jmp_count_q != 32'hFFFF_FFFF))
            jmp_count_d = jmp_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q  <= '0;
            jmp_count_q <= '0;
        end else begin
            br_count_q  <= br_count_d;
            jmp_count_q <= jmp_count_d;
        end
    end

    assign br_count  = br_count_q;
    assign jmp_count = jmp_count_q;
`else
    // Redirect statistics counters are not built.
`endif

endmodule

// File: tb/tb_next_pc_ctrl.sv
module tb_next_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_taken, jump;
    logic [31:0] id_pc_plus4, br_offset;
    logic [25:0] jump_index;
    logic [31:0] pc, pc_plus4;
    logic        if_flush, redirect;
`ifdef NEXT_PC_BR_STATS_EN
    logic [31:0] br_count, jmp_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        fl;
        logic        rd;
    } exp_t;

    exp_t exp_q[$];
    int   step_id = 0;

    next_pc_ctrl #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .jump        (jump),
        .id_pc_plus4 (id_pc_plus4),
        .br_offset   (br_offset),
        .jump_index  (jump_index),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .if_flush    (if_flush),
        .redirect    (redirect)
`ifdef NEXT_PC_BR_STATS_EN
        ,
        .br_count    (br_count),
        .jmp_count   (jmp_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, id, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int id, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b, expected %b", name, id, act, exp);
        end
    endtask

    // Called on a falling edge: drive inputs for the next rising edge and
    // queue the state expected right after it, then move to the next falling edge.
    task automatic step(input logic s, input logic b, input logic j,
                        input logic [31:0] idp4, input logic [31:0] off, input logic [25:0] jidx,
                        input logic [31:0] e_pc, input logic e_fl, input logic e_rd);
        exp_t e;
        stall       = s;
        br_taken    = b;
        jump        = j;
        id_pc_plus4 = idp4;
        br_offset   = off;
        jump_index  = jidx;
        step_id++;
        e.id = step_id;
        e.pc = e_pc;
        e.fl = e_fl;
        e.rd = e_rd;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every rising edge, let the outputs settle, then consume one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk32("pc", e.id, pc, e.pc);
                chk32("pc_plus4", e.id, pc_plus4, e.pc + 32'd4);
                chk1("if_flush", e.id, if_flush, e.fl);
                chk1("redirect", e.id, redirect, e.rd);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        br_taken    = 1'b0;
        jump        = 1'b0;
        id_pc_plus4 = '0;
        br_offset   = '0;
        jump_index  = '0;
        repeat (2) @(negedge clk);
        chk32("reset_pc", 0, pc, 32'h0);
        chk1("reset_flush", 0, if_flush, 1'b0);
        chk1("reset_redirect", 0, redirect, 1'b0);

        rst_n = 1'b1;
        // BOOT: a jump request is ignored, pc stays at RESET_PC.
        step(0, 0, 1, 32'h1000_0040, 32'h0, 26'h10, 32'h0000_0000, 0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0000_0004, 0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0000_0008, 0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0000_000C, 0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0000_0010, 0, 0);
        // Forward branch 0x0C + 3*4.
        step(0, 1, 0, 32'h0000_000C, 32'h3, 26'h0, 32'h0000_0018, 1, 1);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0000_001C, 0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0000_0020, 0, 0);
        // Backward branch 0x40 - 8.
        step(0, 1, 0, 32'h0000_0040, 32'hFFFF_FFFE, 26'h0, 32'h0000_0038, 1, 1);
        // br_taken during FLUSH is ignored.
        step(0, 1, 0, 32'h0000_0100, 32'h4, 26'h0, 32'h0000_003C, 0, 0);
        // Jump {0x1, 0x10, 00}.
        step(0, 0, 1, 32'h1000_0040, 32'h0, 26'h10, 32'h1000_0040, 1, 1);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h1000_0044, 0, 0);
        // Stalled branch is not taken, then taken when stall drops.
        step(1, 1, 0, 32'h0000_0200, 32'h10, 26'h0, 32'h1000_0044, 0, 0);
        step(0, 1, 0, 32'h0000_0200, 32'h10, 26'h0, 32'h0000_0240, 1, 1);
        // Stall during FLUSH holds pc and if_flush, drops redirect.
        step(1, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0000_0240, 1, 0);
        step(1, 0, 1, 32'h0, 32'h0, 26'h1234, 32'h0000_0240, 1, 0);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0000_0244, 0, 0);
        // Branch beats jump (jump would go to 0x0FFF_FFFC).
        step(0, 1, 1, 32'h0000_0300, 32'h1, 26'h3FF_FFFF, 32'h0000_0304, 1, 1);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0000_0308, 0, 0);
        // Jump to top of memory, wrap on the FLUSH advance.
        step(0, 0, 1, 32'hF000_0000, 32'h0, 26'h3FF_FFFF, 32'hFFFF_FFFC, 1, 1);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0000_0000, 0, 0);
        // Wrap on a plain RUN advance.
        step(0, 0, 1, 32'hF000_0000, 32'h0, 26'h3FF_FFFE, 32'hFFFF_FFF8, 1, 1);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0000_0000, 0, 0);
        // Branch into FLUSH, then reset asynchronously mid-FLUSH.
        step(0, 1, 0, 32'h0000_0080, 32'h0, 26'h0, 32'h0000_0080, 1, 1);

`ifdef NEXT_PC_BR_STATS_EN
        chk32("br_count", step_id, br_count, 32'd5);
        chk32("jmp_count", step_id, jmp_count, 32'd3);
`endif

        #2;
        rst_n = 1'b0;
        #1;
        chk32("async_reset_pc", step_id, pc, 32'h0);
        chk1("async_reset_flush", step_id, if_flush, 1'b0);
        chk1("async_reset_redirect", step_id, redirect, 1'b0);
`ifdef NEXT_PC_BR_STATS_EN
        chk32("async_reset_br_count", step_id, br_count, 32'd0);
        chk32("async_reset_jmp_count", step_id, jmp_count, 32'd0);
`endif

        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 32'h0000_0400, 32'h0, 26'h0, 32'h0000_0000, 0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0000_0004, 0, 0);

        // Every queued expectation must have been consumed by the monitor.
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
